// File: rtl/motion_sequencer.sv
// Key-to-step front end: per-channel debounce and auto-repeat, plus a
// frame-synchronous burst FSM that issues a rotate step, then a move step.

module motion_key_channel #(
  parameter int DB_CYCLES     = 50000,
  parameter int REPEAT_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] raw,
  input  logic       frame_done,
  input  logic       issue,
  output logic       pend,
  output logic [1:0] pdir
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int RCW = $clog2(REPEAT_FRAMES + 1);

  logic [1:0]     raw_prev_r, stb_r, stb_s, dir_old_s, dir_new_s, pdir_r;
  logic [DBW-1:0] dbc_r, dbc_s;
  logic [RCW-1:0] rc_r;
  logic           pend_r, press_s, drop_s, frame_held_s, wrap_s;

  function automatic logic [1:0] norm_dir(input logic [1:0] v);
    return (v == 2'b11) ? 2'b00 : v;
  endfunction

  // Debounce: a new raw level must persist DB_CYCLES cycles to replace stb
  always_comb begin
    stb_s = stb_r;
    dbc_s = {DBW{1'b0}};
    if (raw == stb_r) begin
      dbc_s = {DBW{1'b0}};
    end else begin
      if (raw != raw_prev_r) begin
        dbc_s = DBW'(1);
      end else begin
        dbc_s = dbc_r + DBW'(1);
      end
      if (dbc_s == DBW'(DB_CYCLES)) begin
        stb_s = raw;
        dbc_s = {DBW{1'b0}};
      end else begin
        stb_s = stb_r;
      end
    end
  end

  // Edge classification on the normalised stable level
  always_comb begin
    dir_old_s    = norm_dir(stb_r);
    dir_new_s    = norm_dir(stb_s);
    press_s      = (dir_new_s != 2'b00) && (dir_new_s != dir_old_s);
    drop_s       = (dir_new_s == 2'b00) && (dir_old_s != 2'b00);
    frame_held_s = (dir_new_s != 2'b00) && (dir_new_s == dir_old_s) && frame_done;
    wrap_s       = frame_held_s && (rc_r == RCW'(REPEAT_FRAMES - 1));
  end

  // Debounce state plus pending request; a new request beats an issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_prev_r <= 2'b00;
      stb_r      <= 2'b00;
      dbc_r      <= {DBW{1'b0}};
      pend_r     <= 1'b0;
      pdir_r     <= 2'b00;
      rc_r       <= {RCW{1'b0}};
    end else begin
      raw_prev_r <= raw;
      stb_r      <= stb_s;
      dbc_r      <= dbc_s;
      if (press_s || wrap_s) begin
        pend_r <= 1'b1;
        pdir_r <= dir_new_s;
        rc_r   <= {RCW{1'b0}};
      end else if (drop_s) begin
        pend_r <= 1'b0;
        rc_r   <= {RCW{1'b0}};
      end else begin
        if (issue) pend_r <= 1'b0;
        if (frame_held_s) rc_r <= rc_r + RCW'(1);
      end
    end
  end

  assign pend = pend_r;
  assign pdir = pdir_r;
endmodule

module motion_sequencer #(
  parameter int DB_CYCLES     = 50000,
  parameter int REPEAT_FRAMES = 4,
  parameter int SETTLE_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  key_rotate,
  input  logic [1:0]  key_move,
  input  logic        frame_done,
  output logic [1:0]  rotate,
  output logic [1:0]  move,
  output logic        busy,
  output logic [15:0] step_count
);
  localparam int SCW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, MOV = 2'd2, SETTLE = 2'd3} state_t;

  state_t         state_r, state_s;
  logic [SCW-1:0] sc_r;
  logic           want_mov_r;
  logic           pend_rot_s, pend_mov_s, issue_rot_s, issue_mov_s;
  logic [1:0]     pdir_rot_s, pdir_mov_s, rotate_s, move_s;

  motion_key_channel #(.DB_CYCLES(DB_CYCLES), .REPEAT_FRAMES(REPEAT_FRAMES)) u_rot (
    .clk(clk), .rst(rst), .raw(key_rotate), .frame_done(frame_done),
    .issue(issue_rot_s), .pend(pend_rot_s), .pdir(pdir_rot_s)
  );

  motion_key_channel #(.DB_CYCLES(DB_CYCLES), .REPEAT_FRAMES(REPEAT_FRAMES)) u_mov (
    .clk(clk), .rst(rst), .raw(key_move), .frame_done(frame_done),
    .issue(issue_mov_s), .pend(pend_mov_s), .pdir(pdir_mov_s)
  );

  // State register; a move joins the burst only if it was pending at start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      sc_r       <= {SCW{1'b0}};
      want_mov_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == SETTLE) && (state_s == SETTLE)) begin
        sc_r <= sc_r + SCW'(1);
      end else begin
        sc_r <= {SCW{1'b0}};
      end
      if (state_r == IDLE) want_mov_r <= pend_mov_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_done && (pend_rot_s || pend_mov_s)) begin
          state_s = pend_rot_s ? ROT : MOV;
        end else begin
          state_s = IDLE;
        end
      end
      ROT:     state_s = (want_mov_r && pend_mov_s) ? MOV : SETTLE;
      MOV:     state_s = SETTLE;
      SETTLE:  state_s = (sc_r == SCW'(SETTLE_CYC - 1)) ? IDLE : SETTLE;
      default: state_s = IDLE;
    endcase
  end

  // Strobe values for the state being entered
  always_comb begin
    rotate_s    = 2'b00;
    move_s      = 2'b00;
    issue_rot_s = 1'b0;
    issue_mov_s = 1'b0;
    case (state_s)
      ROT: begin
        rotate_s    = pdir_rot_s;
        issue_rot_s = 1'b1;
      end
      MOV: begin
        move_s      = pdir_mov_s;
        issue_mov_s = 1'b1;
      end
      default: begin
        rotate_s = 2'b00;
        move_s   = 2'b00;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rotate     <= 2'b00;
      move       <= 2'b00;
      busy       <= 1'b0;
      step_count <= 16'd0;
    end else begin
      rotate     <= rotate_s;
      move       <= move_s;
      busy       <= (state_s != IDLE);
      step_count <= step_count + {15'd0, issue_rot_s | issue_mov_s};
    end
  end
endmodule

// File: tb/tb_motion_sequencer.sv
// Self-checking bench for motion_sequencer: directed table, hand sequences,
// and randomized stimulus against a behavioural model.

module tb_motion_sequencer;
  localparam int DB = 8;
  localparam int RF = 4;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  key_rotate, key_move;
  logic        frame_done;
  logic [1:0]  rotate, move;
  logic        busy;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  motion_sequencer #(.DB_CYCLES(DB), .REPEAT_FRAMES(RF), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .key_rotate(key_rotate), .key_move(key_move),
    .frame_done(frame_done), .rotate(rotate), .move(move), .busy(busy),
    .step_count(step_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model state
  int m_prev[2], m_run[2], m_stb[2], m_pend[2], m_pdir[2], m_rc[2];
  int m_left, m_cnt, m_mov_due;
  int e_rot, e_mov, e_busy;

  function automatic int norm(input int v);
    return (v == 3) ? 0 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_prev[c] = 0; m_run[c] = 0; m_stb[c] = 0;
      m_pend[c] = 0; m_pdir[c] = 0; m_rc[c] = 0;
    end
    m_left = 0; m_cnt = 0; m_mov_due = 0;
    e_rot = 0; e_mov = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    int raw[2];
    int iss[2];
    int od, nd, fd;
    raw[0] = int'(key_rotate);
    raw[1] = int'(key_move);
    fd = int'(frame_done);
    iss[0] = 0; iss[1] = 0;
    e_rot = 0; e_mov = 0;
    if (m_left == 0) begin
      if (fd == 1 && (m_pend[0] == 1 || m_pend[1] == 1)) begin
        if (m_pend[0] == 1) begin
          e_rot = m_pdir[0]; iss[0] = 1;
          m_mov_due = m_pend[1];
          m_left = SC + 1 + m_pend[1];
        end else begin
          e_mov = m_pdir[1]; iss[1] = 1;
          m_mov_due = 0;
          m_left = SC + 1;
        end
      end
    end else if (m_mov_due == 1) begin
      m_mov_due = 0;
      if (m_pend[1] == 1) begin
        e_mov = m_pdir[1]; iss[1] = 1;
        m_left = m_left - 1;
      end else begin
        m_left = m_left - 2;
      end
    end else begin
      m_left = m_left - 1;
    end
    m_cnt = (m_cnt + iss[0] + iss[1]) % 65536;
    e_busy = (m_left != 0) ? 1 : 0;
    for (int c = 0; c < 2; c++) begin
      od = norm(m_stb[c]);
      m_run[c] = (raw[c] == m_prev[c]) ? m_run[c] + 1 : 1;
      m_prev[c] = raw[c];
      if (raw[c] != m_stb[c] && m_run[c] == DB) m_stb[c] = raw[c];
      nd = norm(m_stb[c]);
      if (iss[c] == 1) m_pend[c] = 0;
      if (nd != 0 && nd != od) begin
        m_pend[c] = 1; m_pdir[c] = nd; m_rc[c] = 0;
      end else if (nd == 0 && od != 0) begin
        m_pend[c] = 0; m_rc[c] = 0;
      end else if (nd != 0 && fd == 1) begin
        m_rc[c] = m_rc[c] + 1;
        if (m_rc[c] == RF) begin
          m_pend[c] = 1; m_pdir[c] = nd; m_rc[c] = 0;
        end
      end
    end
  endtask

  // One clock: advance the model, let the edge pass, compare away from it
  task automatic tick();
    if (rst) model_reset(); else model_edge();
    @(posedge clk);
    #1;
    check("model_rotate", rotate, e_rot);
    check("model_move", move, e_mov);
    check("model_busy", busy, e_busy);
    check("model_step_count", step_count, m_cnt);
  endtask

  typedef struct {
    logic [1:0]  kr;
    logic [1:0]  km;
    logic        fd;
    int          n;
    logic [1:0]  er;
    logic [1:0]  em;
    logic        eb;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // glitch reject, single rotate, simultaneous pair, illegal code, press-release
    tbl.push_back('{2'b01, 2'b00, 1'b0, 7,  2'b00, 2'b00, 1'b0, 16'd0});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0, 16'd0});
    tbl.push_back('{2'b00, 2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b0, 16'd0});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 8,  2'b00, 2'b00, 1'b0, 16'd0});
    tbl.push_back('{2'b01, 2'b00, 1'b1, 1,  2'b01, 2'b00, 1'b1, 16'd1});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b1, 16'd1});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 2,  2'b00, 2'b00, 1'b0, 16'd1});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 9,  2'b00, 2'b00, 1'b0, 16'd1});
    tbl.push_back('{2'b10, 2'b10, 1'b0, 8,  2'b00, 2'b00, 1'b0, 16'd1});
    tbl.push_back('{2'b10, 2'b10, 1'b1, 1,  2'b10, 2'b00, 1'b1, 16'd2});
    tbl.push_back('{2'b10, 2'b10, 1'b0, 1,  2'b00, 2'b10, 1'b1, 16'd3});
    tbl.push_back('{2'b10, 2'b10, 1'b0, 1,  2'b00, 2'b00, 1'b1, 16'd3});
    tbl.push_back('{2'b10, 2'b10, 1'b0, 1,  2'b00, 2'b00, 1'b1, 16'd3});
    tbl.push_back('{2'b10, 2'b10, 1'b0, 1,  2'b00, 2'b00, 1'b0, 16'd3});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 9,  2'b00, 2'b00, 1'b0, 16'd3});
    tbl.push_back('{2'b11, 2'b00, 1'b0, 10, 2'b00, 2'b00, 1'b0, 16'd3});
    tbl.push_back('{2'b11, 2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b0, 16'd3});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 9,  2'b00, 2'b00, 1'b0, 16'd3});
    tbl.push_back('{2'b01, 2'b00, 1'b0, 8,  2'b00, 2'b00, 1'b0, 16'd3});
    tbl.push_back('{2'b00, 2'b00, 1'b0, 8,  2'b00, 2'b00, 1'b0, 16'd3});
    tbl.push_back('{2'b00, 2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b0, 16'd3});

    // Reset held with keys active
    rst = 1'b1; key_rotate = 2'b01; key_move = 2'b10; frame_done = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset_rotate", rotate, 2'b00);
    check("reset_move", move, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_step_count", step_count, 16'd0);
    rst = 1'b0; key_rotate = 2'b00; key_move = 2'b00; frame_done = 1'b0;
    repeat (100) tick();
    check("idle_no_steps", step_count, 16'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      key_rotate = tbl[i].kr; key_move = tbl[i].km; frame_done = tbl[i].fd;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d_rotate", i), rotate, tbl[i].er);
      check($sformatf("vec%0d_move", i), move, tbl[i].em);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      check($sformatf("vec%0d_step_count", i), step_count, tbl[i].ec);
    end
    frame_done = 1'b0;

    // Auto-repeat: held move over 9 frames steps at frames 1, 5 and 9
    key_move = 2'b01;
    repeat (8) tick();
    for (int f = 1; f <= 9; f++) begin
      frame_done = 1'b1;
      tick();
      check($sformatf("repeat_frame%0d_move", f), move, (f == 1 || f == 5 || f == 9) ? 2'b01 : 2'b00);
      frame_done = 1'b0;
      repeat (9) tick();
    end
    check("repeat_step_count", step_count, 16'd6);
    key_move = 2'b00;
    repeat (9) tick();

    // Asynchronous reset during ROT
    key_rotate = 2'b01;
    repeat (8) tick();
    frame_done = 1'b1;
    tick();
    check("pre_reset_rotate", rotate, 2'b01);
    frame_done = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_rotate", rotate, 2'b00);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_step_count", step_count, 16'd0);
    model_reset();
    key_rotate = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    repeat (9) tick();
    frame_done = 1'b1;
    tick();
    check("post_reset_rotate", rotate, 2'b00);
    check("post_reset_step_count", step_count, 16'd0);
    frame_done = 1'b0;

    // Randomized stimulus against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 11) == 0) key_rotate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) key_move = 2'($urandom_range(0, 3));
      frame_done = ($urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
      check("never_both", {31'd0, (rotate != 2'b00) && (move != 2'b00)}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
